// File: rtl/ss_wb_responder.sv
// rtl/ss_wb_responder.sv - Wishbone responder memory with wait states, retry, error injection and linear bursts
module ss_wb_responder #(
    parameter int          DW   = 32,
    parameter int          AW   = 10,
    parameter logic [31:0] BASE = 32'h0000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [31:0]     wbm_adr_o,
    input  logic [DW-1:0]   wbm_dat_o,
    input  logic [DW/8-1:0] wbm_sel_o,
    input  logic            wbm_we_o,
    input  logic            wbm_stb_o,
    input  logic            wbm_cyc_o,
    input  logic            wbm_cab_o,
    output logic [DW-1:0]   wbm_dat_i,
    output logic            wbm_ack_i,
    output logic            wbm_err_i,
    output logic            wbm_rty_i,
    input  logic [3:0]      cfg_wait,
    input  logic            cfg_err_en,
    input  logic [31:0]     cfg_err_adr,
    input  logic [2:0]      cfg_rty_cnt,
    output logic [15:0]     rd_cnt,
    output logic [15:0]     wr_cnt
);
    localparam int          NB   = DW / 8;
    localparam int          SH   = $clog2(NB);
    localparam logic [32:0] SPAN = 33'(NB) << AW;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;
    state_t state, next_state;

    logic [DW-1:0] mem [2**AW];
    logic [31:0]   adr_q, err_adr_q;
    logic [AW-1:0] idx_q;
    logic          we_q, cab_q, err_en_q, cyc_d;
    logic [3:0]    wait_q;
    logic [2:0]    rty_q;

    logic          active, beat_done, acked, cyc_rise;
    logic [AW-1:0] idx_inc, eval_idx;
    logic [31:0]   eval_adr, eval_off, eval_err_adr;
    logic [32:0]   adr_ext;
    logic          eval_we, eval_err_en, eval_err, eval_rty;
    logic          ack_d, err_d, rty_d;
    logic [DW-1:0] dat_d;

    assign active    = wbm_stb_o & wbm_cyc_o;
    assign cyc_rise  = wbm_cyc_o & ~cyc_d;
    assign beat_done = (state == S_RESP) & active;
    assign acked     = beat_done & wbm_ack_i;
    assign idx_inc   = idx_q + 1'b1;

    // Attributes of the beat about to be presented: live inputs from IDLE,
    // latched context from WAIT, next sequential word while bursting.
    always_comb begin
        eval_adr     = adr_q;
        eval_we      = we_q;
        eval_err_en  = err_en_q;
        eval_err_adr = err_adr_q;
        case (state)
            S_IDLE: begin
                eval_adr     = wbm_adr_o;
                eval_we      = wbm_we_o;
                eval_err_en  = cfg_err_en;
                eval_err_adr = cfg_err_adr;
            end
            S_RESP:  eval_adr = BASE + (32'(idx_inc) << SH);
            default: ;
        endcase
        eval_off = eval_adr - BASE;
        eval_idx = AW'(eval_off >> SH);
        adr_ext  = {1'b0, eval_adr};
        eval_err = (adr_ext < {1'b0, BASE}) || (adr_ext >= ({1'b0, BASE} + SPAN)) ||
                   (eval_err_en && (eval_adr == eval_err_adr));
        eval_rty = cyc_rise ? (cfg_rty_cnt != 3'd0) : (rty_q != 3'd0);
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (active) next_state = (cfg_wait != 4'd0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (!active)              next_state = S_IDLE;
                else if (wait_q <= 4'd1)  next_state = S_RESP;
            end
            S_RESP: begin
                if (!active)                    next_state = S_IDLE;
                else if (wbm_ack_i && cab_q)    next_state = S_RESP;
                else                            next_state = S_HOLD;
            end
            S_HOLD:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Terminations are registered, so they are decided on the edge that enters RESP.
    always_comb begin
        ack_d = 1'b0;
        err_d = 1'b0;
        rty_d = 1'b0;
        dat_d = '0;
        if (next_state == S_RESP) begin
            if (eval_err)      err_d = 1'b1;
            else if (eval_rty) rty_d = 1'b1;
            else begin
                ack_d = 1'b1;
                if (!eval_we) dat_d = mem[eval_idx];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            wbm_ack_i <= 1'b0;
            wbm_err_i <= 1'b0;
            wbm_rty_i <= 1'b0;
            wbm_dat_i <= '0;
            wait_q    <= 4'd0;
            rty_q     <= 3'd0;
            cyc_d     <= 1'b0;
            rd_cnt    <= 16'd0;
            wr_cnt    <= 16'd0;
        end else begin
            state     <= next_state;
            wbm_ack_i <= ack_d;
            wbm_err_i <= err_d;
            wbm_rty_i <= rty_d;
            wbm_dat_i <= dat_d;
            cyc_d     <= wbm_cyc_o;
            if (state == S_WAIT)
                wait_q <= wait_q - 4'd1;
            else if (state == S_IDLE && active)
                wait_q <= cfg_wait;
            if (cyc_rise)
                rty_q <= cfg_rty_cnt;
            else if (beat_done && wbm_rty_i)
                rty_q <= rty_q - 3'd1;
            if (acked) begin
                if (we_q) wr_cnt <= (wr_cnt == 16'hFFFF) ? wr_cnt : wr_cnt + 16'd1;
                else      rd_cnt <= (rd_cnt == 16'hFFFF) ? rd_cnt : rd_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (state == S_IDLE && active) begin
            adr_q     <= wbm_adr_o;
            we_q      <= wbm_we_o;
            cab_q     <= wbm_cab_o;
            err_en_q  <= cfg_err_en;
            err_adr_q <= cfg_err_adr;
        end
        if (next_state == S_RESP) idx_q <= eval_idx;
    end

    // Memory is never cleared; writes commit only on a completed ack beat.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && acked && we_q) begin
            for (int b = 0; b < NB; b++) begin
                if (wbm_sel_o[b]) mem[idx_q][b*8 +: 8] <= wbm_dat_o[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ss_wb_responder.sv
// tb/tb_ss_wb_responder.sv - self-checking bench for ss_wb_responder against a word-array reference model
module tb_ss_wb_responder;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 1024;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [31:0] wbm_adr_o = '0;
    logic [31:0] wbm_dat_o = '0;
    logic [3:0]  wbm_sel_o = '0;
    logic        wbm_we_o = 1'b0, wbm_stb_o = 1'b0, wbm_cyc_o = 1'b0, wbm_cab_o = 1'b0;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic [3:0]  cfg_wait = '0;
    logic        cfg_err_en = 1'b0;
    logic [31:0] cfg_err_adr = '0;
    logic [2:0]  cfg_rty_cnt = '0;
    logic [15:0] rd_cnt, wr_cnt;

    always #5 wb_clk_i = ~wb_clk_i;

    ss_wb_responder #(.DW(32), .AW(10), .BASE(BASE)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o), .wbm_cab_o(wbm_cab_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
        .cfg_wait(cfg_wait), .cfg_err_en(cfg_err_en), .cfg_err_adr(cfg_err_adr), .cfg_rty_cnt(cfg_rty_cnt),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    int          checks = 0, errors = 0;
    logic [31:0] ref_mem [DEPTH];
    int          ref_rd = 0, ref_wr = 0;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_is_err(input logic [31:0] a, input bit een, input logic [31:0] ea);
        return (a < BASE) || (a >= BASE + 32'd4096) || (een && a == ea);
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'(((a - BASE) / 32'd4) % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic run_cycle(input string tag, input logic [31:0] a, input bit w_en, input logic [3:0] s,
                             input logic [31:0] wd, input int w, input int rc, input bit een, input logic [31:0] ea);
        bit exp_err, first, done;
        int n, rtys;
        exp_err = ref_is_err(a, een, ea);
        cfg_wait = 4'(w); cfg_rty_cnt = 3'(rc); cfg_err_en = een; cfg_err_adr = ea;
        wbm_adr_o = a; wbm_we_o = w_en; wbm_sel_o = s; wbm_dat_o = wd; wbm_cab_o = 1'b0;
        wbm_cyc_o = 1'b1; wbm_stb_o = 1'b1;
        n = 0; rtys = 0; first = 1'b1; done = 1'b0;
        while (!done) begin
            @(posedge wb_clk_i); #1; n++;
            if (n > 200) begin
                check({tag, " timeout"}, 32'd0, 32'd1);
                done = 1'b1;
            end else if (wbm_ack_i || wbm_err_i || wbm_rty_i) begin
                if (first) begin
                    check({tag, " latency"}, 32'(n), 32'(w + 1));
                    first = 1'b0;
                end
                if (wbm_rty_i && !wbm_err_i && !wbm_ack_i) begin
                    rtys++;
                end else begin
                    done = 1'b1;
                    check({tag, " kind"}, 32'({wbm_ack_i, wbm_err_i, wbm_rty_i}), exp_err ? 32'd2 : 32'd4);
                    if (wbm_ack_i && !w_en) begin
                        last_rdata = wbm_dat_i;
                        check({tag, " rdata"}, wbm_dat_i, ref_mem[ref_idx(a)]);
                    end
                end
                @(posedge wb_clk_i); #1; n++;
                check({tag, " hold"}, {wbm_dat_i[28:0], wbm_ack_i, wbm_err_i, wbm_rty_i}, 32'd0);
            end
        end
        wbm_stb_o = 1'b0; wbm_cyc_o = 1'b0;
        check({tag, " retries"}, 32'(rtys), exp_err ? 32'd0 : 32'(rc));
        if (!exp_err) begin
            if (w_en) begin
                ref_mem[ref_idx(a)] = ref_merge(ref_mem[ref_idx(a)], wd, s);
                ref_wr++;
            end else begin
                ref_rd++;
            end
        end
        check({tag, " rd_cnt"}, 32'(rd_cnt), 32'(ref_rd));
        check({tag, " wr_cnt"}, 32'(wr_cnt), 32'(ref_wr));
        @(posedge wb_clk_i); #1;
    endtask

    task automatic run_burst(input string tag, input logic [31:0] a, input int beats);
        int i0;
        i0 = ref_idx(a);
        cfg_wait = 4'd0; cfg_rty_cnt = 3'd0; cfg_err_en = 1'b0;
        wbm_adr_o = a; wbm_we_o = 1'b0; wbm_cab_o = 1'b1; wbm_cyc_o = 1'b1; wbm_stb_o = 1'b1;
        for (int k = 0; k < beats; k++) begin
            @(posedge wb_clk_i); #1;
            check($sformatf("%s ack%0d", tag, k), 32'(wbm_ack_i), 32'd1);
            check($sformatf("%s data%0d", tag, k), wbm_dat_i, ref_mem[(i0 + k) % DEPTH]);
        end
        @(posedge wb_clk_i); #1;
        wbm_stb_o = 1'b0; wbm_cyc_o = 1'b0; wbm_cab_o = 1'b0;
        @(posedge wb_clk_i); #1;
        check({tag, " end"}, 32'({wbm_ack_i, wbm_err_i, wbm_rty_i}), 32'd0);
        ref_rd += beats;
        check({tag, " rd_cnt"}, 32'(rd_cnt), 32'(ref_rd));
        @(posedge wb_clk_i); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, ea;
        int rd0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst ack", 32'(wbm_ack_i), 32'd0);
        check("rst err_rty", 32'({wbm_err_i, wbm_rty_i}), 32'd0);
        check("rst dat", wbm_dat_i, 32'd0);
        check("rst cnt", {rd_cnt, wr_cnt}, 32'd0);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        for (int i = 0; i < 16; i++)
            run_cycle("init", BASE + 32'(4 * i), 1'b1, 4'hF, $urandom, 0, 0, 1'b0, 32'd0);
        run_cycle("init_last", BASE + 32'hFFC, 1'b1, 4'hF, $urandom, 0, 0, 1'b0, 32'd0);

        run_cycle("w_deadbeef", BASE + 32'd8, 1'b1, 4'hF, 32'hDEADBEEF, 3, 0, 1'b0, 32'd0);
        run_cycle("r_deadbeef", BASE + 32'd8, 1'b0, 4'hF, 32'd0, 3, 0, 1'b0, 32'd0);
        check("deadbeef value", last_rdata, 32'hDEADBEEF);

        run_cycle("w_aaaa", BASE + 32'h10, 1'b1, 4'hF, 32'hAAAAAAAA, 0, 0, 1'b0, 32'd0);
        run_cycle("w_sel5", BASE + 32'h10, 1'b1, 4'b0101, 32'h11223344, 1, 0, 1'b0, 32'd0);
        run_cycle("r_sel5", BASE + 32'h10, 1'b0, 4'hF, 32'd0, 0, 0, 1'b0, 32'd0);
        check("sel5 value", last_rdata, 32'hAA22AA44);

        run_burst("burst_wrap", BASE + 32'hFFC, 4);

        run_cycle("rty2", BASE + 32'h14, 1'b0, 4'hF, 32'd0, 0, 2, 1'b0, 32'd0);

        run_cycle("err_inj", BASE + 32'd4, 1'b1, 4'hF, 32'h5555_AAAA, 0, 0, 1'b1, BASE + 32'd4);
        run_cycle("err_chk", BASE + 32'd4, 1'b0, 4'hF, 32'd0, 0, 0, 1'b0, 32'd0);
        run_cycle("err_below", BASE - 32'd4, 1'b0, 4'hF, 32'd0, 2, 0, 1'b0, 32'd0);
        run_cycle("err_above", BASE + 32'h1000, 1'b1, 4'hF, 32'd1, 0, 1, 1'b0, 32'd0);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) != 0) ? BASE + 32'h1000 + 32'(4 * $urandom_range(0, 63))
                                                : BASE - 32'(4 * $urandom_range(1, 63));
            else
                a = BASE + 32'(4 * $urandom_range(0, 15));
            ea = ($urandom_range(0, 1) != 0) ? a : BASE + 32'(4 * $urandom_range(0, 15));
            run_cycle($sformatf("rand%0d", t), a, 1'($urandom_range(0, 1)), 4'($urandom),
                      $urandom, $urandom_range(0, 4), $urandom_range(0, 2),
                      ($urandom_range(0, 3) == 0), ea);
        end

        cfg_wait = 4'd6; cfg_rty_cnt = 3'd0; cfg_err_en = 1'b0;
        wbm_adr_o = BASE + 32'h20; wbm_we_o = 1'b1; wbm_sel_o = 4'hF; wbm_dat_o = 32'h0BAD0BAD;
        wbm_cyc_o = 1'b1; wbm_stb_o = 1'b1;
        @(posedge wb_clk_i); #1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        check("midrst term", 32'({wbm_ack_i, wbm_err_i, wbm_rty_i}), 32'd0);
        check("midrst dat", wbm_dat_i, 32'd0);
        check("midrst cnt", {rd_cnt, wr_cnt}, 32'd0);
        wb_rst_i = 1'b0; wbm_stb_o = 1'b0; wbm_cyc_o = 1'b0;
        ref_rd = 0; ref_wr = 0;
        @(posedge wb_clk_i); #1;
        rd0 = ref_idx(BASE + 32'h20);
        run_cycle("midrst read", BASE + 32'h20, 1'b0, 4'hF, 32'd0, 0, 0, 1'b0, 32'd0);
        check("midrst word", last_rdata, ref_mem[rd0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ss_wb_responder.md
SS_WB_RESPONDER -- requirements
Module: ss_wb_responder

Interface
REQ-001 Parameter DW, default 32, data width in bits; legal values 32 and 64.
REQ-002 Parameter AW, default 10, log2 of memory depth in DW-bit words.
REQ-003 Parameter BASE, default 32'h0000_0000, byte base address of the memory window.
REQ-004 wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-005 wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 wbm_adr_o  in  32  byte address from the master under test.
REQ-007 wbm_dat_o  in  DW  write data.
REQ-008 wbm_sel_o  in  DW/8  byte enables.
REQ-009 wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_cab_o  in  1 each  write enable, strobe, cycle, linear burst.
REQ-010 wbm_dat_i  out  DW  read data.
REQ-011 wbm_ack_i, wbm_err_i, wbm_rty_i  out  1 each  termination signals, registered.
REQ-012 cfg_wait  in  4  wait cycles inserted before the first beat of a cycle.
REQ-013 cfg_err_en  in  1  enables error injection at cfg_err_adr.
REQ-014 cfg_err_adr  in  32  byte address that is terminated with err.
REQ-015 cfg_rty_cnt  in  3  number of rty terminations issued before a new cycle is accepted.
REQ-016 rd_cnt, wr_cnt  out  16 each  acked read and write beats, saturating.

Function
REQ-017 The state machine SHALL have states IDLE, WAIT, RESP and HOLD.
REQ-018 IDLE: on stb&cyc, the block SHALL latch adr/we/cab and load the wait counter with cfg_wait; it SHALL go to WAIT if cfg_wait!=0, else to RESP.
REQ-019 WAIT: the counter SHALL decrement each cycle; at 1 the block SHALL go to RESP, so the first termination appears cfg_wait+1 cycles after stb is sampled.
REQ-020 RESP: exactly one of ack/err/rty SHALL be high, priority err > rty > ack.
REQ-021 err SHALL be selected when the address is outside [BASE, BASE+DW/8*2^AW) or when cfg_err_en=1 and address==cfg_err_adr.
REQ-022 rty SHALL be selected while the per-cycle retry counter is nonzero; the counter SHALL load cfg_rty_cnt on cyc rising and decrement per rty.
REQ-023 An acked write SHALL update only the bytes enabled by wbm_sel_o; an acked read SHALL drive the word on wbm_dat_i in the ack cycle, and wbm_dat_i SHALL be 0 otherwise.
REQ-024 Word index SHALL be (adr-BASE)>>log2(DW/8), truncated to AW bits.
REQ-025 After an ack with latched cab=1 and stb still high, the block SHALL stay in RESP, increment the internal address by DW/8 with wrap at 2^AW words, and ack every cycle with no wait states.
REQ-026 After a non-burst ack, or after err/rty, the block SHALL enter HOLD for one cycle with all terminations low, then return to IDLE.
REQ-027 If stb or cyc drops in WAIT or RESP, the block SHALL return to IDLE with no termination and no memory write in that cycle.
REQ-028 rd_cnt/wr_cnt SHALL increment once per acked beat and saturate at 16'hFFFF; err and rty beats SHALL NOT count.
REQ-029 Configuration inputs SHALL be sampled only in IDLE, when a cycle starts.

Reset
REQ-030 With wb_rst_i high at a clock edge, the state SHALL be IDLE, ack/err/rty and wbm_dat_i SHALL be 0, rd_cnt/wr_cnt SHALL be 0, and the retry and wait counters SHALL be 0.
REQ-031 Memory contents SHALL NOT be cleared by reset, and a transfer in progress SHALL be abandoned with no write.

Verification
REQ-032 cfg_wait=3, single write of 32'hDEADBEEF to BASE+8 with sel=4'hF, then a read -> ack 4 cycles after stb, read returns 32'hDEADBEEF, wr_cnt=1, rd_cnt=1.
REQ-033 Write with sel=4'b0101 of 32'h11223344 over 32'hAAAAAAAA -> read returns 32'hAA22AA44.
REQ-034 cab=1 read burst of 4 beats from the last word of the window, cfg_wait=0 -> acks on consecutive cycles, addresses wrap to word 0, rd_cnt=4.
REQ-035 cfg_rty_cnt=2, single read -> rty, HOLD, rty, HOLD, then ack on the third attempt within the same cyc.
REQ-036 cfg_err_en=1, cfg_err_adr=BASE+4, write to BASE+4 -> err for one cycle, memory unchanged; access to BASE-4 -> err.
REQ-037 Assert wb_rst_i during WAIT of a write -> all outputs 0 next cycle, the addressed word unchanged, counters 0.
